ssd_scroll_ctrl: RTL and testbench
==================================

Name: ssd_scroll_ctrl

Overview:
- Scheduler for the shared 4-digit seven-segment display. It time-multiplexes one glyph lookup (row/col code into the alpha glyph ROM) across four anodes.
- Holds a small message buffer of glyph codes loaded through a valid/ready port. Scrolls a 4-digit window across the message when the message is longer than four glyphs.
- Sits between the top-level/host logic and the glyph lookup. Replaces hard-wired per-digit row/col cases.

Parameters:
- MSG_DEPTH, 16: message buffer entries; power of 2, at least 4.
- REFRESH_DIV, 200_000: clk cycles per digit-refresh tick (per anode step).
- SCROLL_DIV, 100_000_000: clk cycles per scroll tick.
- CNT_W, $clog2(MSG_DEPTH+1): width of msg_len.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- wr_valid  in  1  glyph write request.
- wr_ready  out  1  buffer can accept a glyph.
- wr_row  in  3  glyph row code.
- wr_col  in  3  glyph col code.
- clear  in  1  synchronous buffer flush (1-cycle pulse).
- scroll_en  in  1  enables window advance.
- msg_len  out  CNT_W  number of stored glyphs.
- row  out  3  row code to glyph lookup.
- col  out  3  col code to glyph lookup.
- ssd_anode  out  4  active-low one-hot anode drive.

Behaviour:
- Reset (reset=0, async): all of the following are cleared.
  - Buffer count=0, window start=0, digit=0.
  - Both tick counters=0.
  - ssd_anode=4'b1111, row=0, col=0, msg_len=0.
  - wr_ready=1 once reset is released.
- Tick generation:
  - The refresh counter pulses refresh_tick for 1 cycle every REFRESH_DIV cycles.
  - The scroll counter does the same with SCROLL_DIV.
  - Both run freely from reset.
- Write path:
  - Accept when wr_valid && wr_ready. Store {wr_row, wr_col} at index count; count+1.
  - wr_ready = (count < MSG_DEPTH) && !clear.
  - When full, writes are ignored and the buffer stays unchanged.
- Clear: count=0 and start=0 on the next edge. Clear beats a simultaneous write (the write is dropped).
- Digit sequencing:
  - digit (2 bits) increments on refresh_tick and wraps 3→0.
  - digit d maps to anode: 0→0111, 1→1011, 2→1101, 3→1110.
- Entry selection for digit d:
  - idx = start + d. If idx >= count, then idx -= count (one subtraction is sufficient because start < count).
  - If count < 4 and d >= count, the digit is blank.
  - If count == 0, all digits are blank.
- Blank digit: ssd_anode=1111, row=0, col=0.
- Output timing: row, col and ssd_anode are registered. They update exactly 1 cycle after the cycle in which digit or the buffer/start state changes. No glitching between anode and row/col: both come from the same register stage.
- Scrolling:
  - On scroll_tick && scroll_en && count > 4: start = (start == count-1) ? 0 : start+1.
  - When count <= 4, start is forced to 0.
  - Writes during scrolling do not move start.
  - When scroll_en=0, start holds.
- Simultaneous events:
  - scroll_tick together with a write: both apply. The scroll uses the pre-write count.
  - clear together with scroll_tick: clear wins.
- msg_len = count, registered.

Decomposition:
- Shared package (ssd_pkg):
  - NUM_DIGITS=4.
  - GLYPH_ROW_W=3, GLYPH_COL_W=3.
  - Anode pattern constants ANODE_D0..D3 and ANODE_OFF=4'b1111.
- One sub-module, ssd_tick_gen:
  - Parameter DIV.
  - Ports clk, reset (async active-low), enable, tick.
  - Instantiated twice (refresh and scroll).
- Buffer: register array inside ssd_scroll_ctrl. No separate FIFO module.

Test Plan (REFRESH_DIV=4, SCROLL_DIV=64, MSG_DEPTH=8):
- Reset asserted mid-operation with 6 glyphs loaded → ssd_anode=1111, msg_len=0, row=col=0 immediately (async). wr_ready=1 after release.
- Write 3 glyphs (1,3),(3,5),(3,2), scroll_en=1 → digits 0-2 show them with anodes 0111/1011/1101 in refresh order. Digit 3 is blank (1111). start stays 0.
- Write 6 glyphs g0..g5, scroll_en=1 → after each scroll_tick the window shifts by one. After 6 ticks the window is back at g0..g3. The window at start=4 shows g4,g5,g0,g1.
- Fill 8 entries → wr_ready=0. A 9th wr_valid is ignored and msg_len stays 8. Then clear together with wr_valid → msg_len=0, the write is dropped, all digits are blank.
- Refresh sweep: check that anode changes exactly 1 cycle after each refresh_tick, that row/col change in the same cycle as the anode, and that the sequence wraps digit 3→0.
- scroll_en=0 with 6 glyphs across 3 scroll ticks → start is held and the display is unchanged. A write during scroll_en=1 → msg_len increments and the window is not disturbed.

Source files
------------

// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared constants and types for the 4-digit seven-segment display scheduler.
//   NUM_DIGITS        number of multiplexed digits (anodes)
//   GLYPH_ROW_W/COL_W widths of the row/col code into the alpha glyph ROM
//   ANODE_D0..D3      active-low one-hot anode drive per digit
//   ANODE_OFF         all anodes off (blank digit / reset)
//   glyph_t           one message buffer entry {row, col}
//   anode_for_digit   digit index -> anode pattern
// ---------------------------------------------------------------------------
package ssd_pkg;

  localparam int NUM_DIGITS  = 4;
  localparam int GLYPH_ROW_W = 3;
  localparam int GLYPH_COL_W = 3;

  localparam logic [NUM_DIGITS-1:0] ANODE_D0  = 4'b0111;
  localparam logic [NUM_DIGITS-1:0] ANODE_D1  = 4'b1011;
  localparam logic [NUM_DIGITS-1:0] ANODE_D2  = 4'b1101;
  localparam logic [NUM_DIGITS-1:0] ANODE_D3  = 4'b1110;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  typedef struct packed {
    logic [GLYPH_ROW_W-1:0] row;
    logic [GLYPH_COL_W-1:0] col;
  } glyph_t;

  function automatic logic [NUM_DIGITS-1:0] anode_for_digit(input logic [1:0] digit);
    logic [NUM_DIGITS-1:0] anode;
    case (digit)
      2'd0:    anode = ANODE_D0;
      2'd1:    anode = ANODE_D1;
      2'd2:    anode = ANODE_D2;
      2'd3:    anode = ANODE_D3;
      default: anode = ANODE_OFF;
    endcase
    return anode;
  endfunction

endpackage

// File: rtl/ssd_tick_gen.sv
// ---------------------------------------------------------------------------
// ssd_tick_gen
// Free-running tick generator: pulses tick for one cycle every DIV enabled
// cycles. Implemented as a down-counter that fires on its terminal count
// (zero) and reloads DIV-1, so the first tick comes in the first enabled
// cycle after reset and then every DIV cycles.
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous active-low reset (counter cleared to 0)
//   enable  in   counter advances only while high
//   tick    out  one-cycle pulse on terminal count
// ---------------------------------------------------------------------------
module ssd_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (enable) begin
      if (cnt_q == '0) begin
        tick  = 1'b1;
        cnt_d = RELOAD;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ssd_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// ssd_scroll_ctrl
// Scheduler for the shared 4-digit seven-segment display. Holds a small
// message of glyph codes, time-multiplexes one glyph lookup across the four
// anodes and scrolls a 4-digit window across messages longer than 4 glyphs.
// Ports:
//   clk        in   system clock
//   reset      in   asynchronous active-low reset
//   wr_valid   in   glyph write request
//   wr_ready   out  buffer can accept a glyph (not full, no clear this cycle)
//   wr_row     in   glyph row code
//   wr_col     in   glyph col code
//   clear      in   synchronous buffer flush (wins over a same-cycle write)
//   scroll_en  in   enables window advance on scroll ticks
//   msg_len    out  number of stored glyphs
//   row, col   out  registered glyph code for the digit being driven
//   ssd_anode  out  registered active-low one-hot anode drive
// ---------------------------------------------------------------------------
module ssd_scroll_ctrl
  import ssd_pkg::*;
#(
  parameter int MSG_DEPTH   = 16,
  parameter int REFRESH_DIV = 200_000,
  parameter int SCROLL_DIV  = 100_000_000,
  parameter int CNT_W       = $clog2(MSG_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [GLYPH_ROW_W-1:0] wr_row,
  input  logic [GLYPH_COL_W-1:0] wr_col,
  input  logic                   clear,
  input  logic                   scroll_en,
  output logic [CNT_W-1:0]       msg_len,
  output logic [GLYPH_ROW_W-1:0] row,
  output logic [GLYPH_COL_W-1:0] col,
  output logic [NUM_DIGITS-1:0]  ssd_anode
);

  localparam int               AW       = $clog2(MSG_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(MSG_DEPTH);
  localparam logic [CNT_W-1:0] DIGITS_C = CNT_W'(NUM_DIGITS);

  glyph_t                 mem_q [MSG_DEPTH];
  glyph_t                 mem_d [MSG_DEPTH];
  logic [CNT_W-1:0]       count_q, count_d;
  logic [AW-1:0]          start_q, start_d;
  logic [1:0]             digit_q, digit_d;
  logic [NUM_DIGITS-1:0]  anode_q, anode_d;
  logic [GLYPH_ROW_W-1:0] row_q, row_d;
  logic [GLYPH_COL_W-1:0] col_q, col_d;

  logic                   refresh_tick;
  logic                   scroll_tick;
  logic                   wr_accept;
  logic [CNT_W:0]         idx_sum;
  logic [CNT_W:0]         idx_wrap;
  logic [CNT_W-AW:0]      unused_idx_hi;
  glyph_t                 sel_glyph;
  logic                   blank;

  ssd_tick_gen #(.DIV(REFRESH_DIV)) u_refresh_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .tick   (refresh_tick)
  );

  ssd_tick_gen #(.DIV(SCROLL_DIV)) u_scroll_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (1'b1),
    .tick   (scroll_tick)
  );

  // Dropping ready during clear is what makes clear win over a write.
  assign wr_ready  = (count_q < DEPTH_C) && !clear;
  assign wr_accept = wr_valid && wr_ready;

  // Buffer, window start and digit sequencing. The scroll decision looks at
  // count_q, so a same-cycle write does not influence the wrap point.
  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    start_d = start_q;
    digit_d = refresh_tick ? digit_q + 2'd1 : digit_q;

    if (clear) begin
      count_d = '0;
      start_d = '0;
    end else begin
      if (scroll_tick && scroll_en && (count_q > DIGITS_C)) begin
        start_d = (CNT_W'(start_q) == count_q - CNT_W'(1)) ? '0 : start_q + AW'(1);
      end else if (count_q <= DIGITS_C) begin
        start_d = '0;
      end
      if (wr_accept) begin
        mem_d[count_q[AW-1:0]] = '{row: wr_row, col: wr_col};
        count_d                = count_q + CNT_W'(1);
      end
    end
  end

  // Entry for the current digit. start < count whenever count > 0, so
  // start + digit never reaches 2*count and a single conditional subtract
  // replaces a modulo.
  always_comb begin
    idx_sum       = (CNT_W+1)'(start_q) + (CNT_W+1)'(digit_q);
    idx_wrap      = (idx_sum >= {1'b0, count_q}) ? idx_sum - {1'b0, count_q} : idx_sum;
    unused_idx_hi = idx_wrap[CNT_W:AW];
    sel_glyph     = mem_q[idx_wrap[AW-1:0]];
    blank         = (count_q == '0) ||
                    ((count_q < DIGITS_C) && (CNT_W'(digit_q) >= count_q));

    if (blank) begin
      anode_d = ANODE_OFF;
      row_d   = '0;
      col_d   = '0;
    end else begin
      anode_d = anode_for_digit(digit_q);
      row_d   = sel_glyph.row;
      col_d   = sel_glyph.col;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MSG_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
      start_q <= '0;
      digit_q <= '0;
      anode_q <= ANODE_OFF;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
      start_q <= start_d;
      digit_q <= digit_d;
      anode_q <= anode_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Anode and row/col share one register stage so they switch together.
  assign ssd_anode = anode_q;
  assign row       = row_q;
  assign col       = col_q;
  assign msg_len   = count_q;

endmodule

// File: tb/tb_ssd_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ssd_scroll_ctrl
// Randomized and directed stimulus against a queue-based reference model of
// the scrolling display. The model keeps the message as a queue of glyphs,
// the window start as an integer and derives ticks from the cycle count
// since reset release.
// ---------------------------------------------------------------------------
module tb_ssd_scroll_ctrl;

  localparam int MSG_DEPTH   = 8;
  localparam int REFRESH_DIV = 4;
  localparam int SCROLL_DIV  = 64;
  localparam int CNT_W       = $clog2(MSG_DEPTH + 1);

  logic             clk       = 1'b0;
  logic             reset     = 1'b1;
  logic             wr_valid  = 1'b0;
  logic             clear     = 1'b0;
  logic             scroll_en = 1'b0;
  logic [2:0]       wr_row    = '0;
  logic [2:0]       wr_col    = '0;
  logic             wr_ready;
  logic [CNT_W-1:0] msg_len;
  logic [2:0]       row;
  logic [2:0]       col;
  logic [3:0]       ssd_anode;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ssd_scroll_ctrl #(
    .MSG_DEPTH   (MSG_DEPTH),
    .REFRESH_DIV (REFRESH_DIV),
    .SCROLL_DIV  (SCROLL_DIV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .clear     (clear),
    .scroll_en (scroll_en),
    .msg_len   (msg_len),
    .row       (row),
    .col       (col),
    .ssd_anode (ssd_anode)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model
  logic [5:0] msg_m [$];
  int         start_m = 0;
  int         digit_m = 0;
  int         cyc_m   = 0;
  logic [3:0] exp_anode;
  logic [2:0] exp_row;
  logic [2:0] exp_col;

  always @(posedge clk) begin
    int         n;
    logic [5:0] g;
    if (!reset) begin
      msg_m.delete();
      start_m = 0;
      digit_m = 0;
      cyc_m   = 0;
    end else begin
      n = msg_m.size();
      // Outputs seen after this edge reflect the state before it.
      if (n == 0 || (n < 4 && digit_m >= n)) begin
        exp_anode = 4'hF;
        exp_row   = '0;
        exp_col   = '0;
      end else begin
        g         = msg_m[(start_m + digit_m) % n];
        exp_anode = ~(4'b1000 >> digit_m);
        exp_row   = g[5:3];
        exp_col   = g[2:0];
      end
      if (clear) begin
        msg_m.delete();
        start_m = 0;
      end else begin
        if ((cyc_m % SCROLL_DIV) == 0 && scroll_en && n > 4) start_m = (start_m + 1) % n;
        if (wr_valid && n < MSG_DEPTH) msg_m.push_back({wr_row, wr_col});
      end
      if ((cyc_m % REFRESH_DIV) == 0) digit_m = (digit_m + 1) % 4;
      cyc_m++;
      #1;
      check_eq("anode", ssd_anode, exp_anode);
      check_eq("row", row, exp_row);
      check_eq("col", col, exp_col);
      check_eq("msg_len", msg_len, msg_m.size());
      check_eq("wr_ready", wr_ready, (msg_m.size() < MSG_DEPTH) && !clear);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [2:0] r, input logic [2:0] c);
    wr_valid = 1'b1;
    wr_row   = r;
    wr_col   = c;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_anode", ssd_anode, 4'hF);
    check_eq("rst_len", msg_len, 0);
    check_eq("rst_row", row, 0);
    reset = 1'b1;
    #1 check_eq("rel_ready", wr_ready, 1);
    @(negedge clk);

    // Three glyphs: digit 3 stays blank, start stays 0.
    scroll_en = 1'b1;
    put(3'd1, 3'd3);
    put(3'd3, 3'd5);
    put(3'd3, 3'd2);
    idle(200);

    // Six glyphs: window walks through a full cycle of six scroll ticks.
    pulse_clear();
    for (int i = 0; i < 6; i++) put(3'($urandom), 3'($urandom));
    idle(6 * SCROLL_DIV + 20);

    // Scrolling disabled across three ticks, then a write while scrolling.
    scroll_en = 1'b0;
    idle(3 * SCROLL_DIV + 10);
    scroll_en = 1'b1;
    put(3'($urandom), 3'($urandom));
    idle(150);

    // Fill, overflow attempt, then clear together with a write.
    pulse_clear();
    for (int i = 0; i < MSG_DEPTH; i++) put(3'($urandom), 3'($urandom));
    check_eq("full_ready", wr_ready, 0);
    check_eq("full_len", msg_len, MSG_DEPTH);
    put(3'($urandom), 3'($urandom));
    check_eq("ovf_len", msg_len, MSG_DEPTH);
    clear    = 1'b1;
    wr_valid = 1'b1;
    #1 check_eq("clr_ready", wr_ready, 0);
    @(negedge clk);
    clear    = 1'b0;
    wr_valid = 1'b0;
    check_eq("clr_len", msg_len, 0);
    idle(20);

    // Random traffic.
    repeat (1500) begin
      wr_valid = ($urandom_range(0, 15) == 0);
      wr_row   = 3'($urandom);
      wr_col   = 3'($urandom);
      clear    = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 199) == 0) scroll_en = ~scroll_en;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    clear    = 1'b0;

    // Asynchronous reset in the middle of a 6-glyph message.
    pulse_clear();
    scroll_en = 1'b1;
    for (int i = 0; i < 6; i++) put(3'($urandom), 3'($urandom));
    idle(10);
    #2 reset = 1'b0;
    #1;
    check_eq("arst_anode", ssd_anode, 4'hF);
    check_eq("arst_len", msg_len, 0);
    check_eq("arst_row", row, 0);
    check_eq("arst_col", col, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 check_eq("arst_ready", wr_ready, 1);
    idle(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
